fir4_input_packer: RTL
======================

Name: fir4_input_packer

Overview:
- Producer side of the 4-parallel FIR sample interface.
- Accepts a serial signed sample stream under valid/ready and packs four consecutive samples into one block, x4k..x4k_3, for the 4-parallel FIR.
- Double-buffered: one block is assembled while the previous one is held at the output. Partial blocks are closed by a flush, which zero-pads the unfilled lanes.

Parameters:
- DW, 16, sample width in bits (signed, two's complement).
- CW, 16, width of the emitted-block counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted when 1).
- s_data  in  DW  signed input sample.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  packer accepts s_data this cycle.
- flush  in  1  level request to close the current partial block.
- flush_ack  out  1  one-cycle pulse: the flush was acted on.
- x4k  out  DW  lane 0, the first sample of the block.
- x4k_1  out  DW  lane 1.
- x4k_2  out  DW  lane 2.
- x4k_3  out  DW  lane 3, the last sample of the block.
- blk_valid  out  1  the output block is valid.
- blk_ready  in  1  the FIR consumes the block this cycle.
- blk_fill  out  3  number of real lanes in the output block (1..4); the remaining upper lanes are 0.
- blk_cnt  out  CW  count of emitted blocks.

Behaviour:
- Reset (asynchronous, any time, including mid-block): x4k..x4k_3 = 0, blk_valid = 0, blk_fill = 0, blk_cnt = 0, flush_ack = 0, fill counter cnt = 0, assembly registers a0..a2 = 0. A partial block in progress is discarded.
- Definitions:
  - Accept = s_valid & s_ready.
  - Consume = blk_valid & blk_ready.
  - slot_free = !blk_valid | blk_ready.
- cnt (2 bits) is the state: FILL0..FILL3 = number of samples held in a0..a2.
- s_ready = !(cnt == 3 & !slot_free). This is combinational from blk_ready and is the only combinational path.
- Accept with cnt < 3: a[cnt] <= s_data; cnt <= cnt + 1.
- Accept with cnt == 3 (slot_free is implied):
  - {x4k, x4k_1, x4k_2, x4k_3} <= {a0, a1, a2, s_data}.
  - blk_fill <= 4, blk_valid <= 1, cnt <= 0, blk_cnt <= blk_cnt + 1.
- Latency: the block appears on the cycle after the 4th sample is accepted.
- Consume with no new block loaded the same cycle: blk_valid <= 0. Output data holds its last value; it does not return to zero.
- Consume and a new load in the same cycle: the new block replaces the old one, and blk_valid stays 1 (back-to-back blocks at one block per 4 accepts, with no bubble).
- The output registers are stable while blk_valid & !blk_ready.
- Flush is acted on when flush = 1, cnt != 0 (after any same-cycle accept), and slot_free. Then:
  - The lanes load {a0, a1 or 0, a2 or 0, 0}, where only the first cnt' lanes are real (cnt' = post-accept count).
  - blk_fill <= cnt', blk_valid <= 1, cnt <= 0, blk_cnt increments, and flush_ack pulses on the next cycle.
- Flush boundary conditions:
  - Flush in the same cycle as an accept with cnt < 3: the new sample is included in the flushed block.
  - Flush in the same cycle as an accept with cnt == 3: a normal full block is emitted, flush_ack = 1, and nothing further happens.
  - Flush with cnt == 0 and no accept: flush_ack pulses and no block is emitted.
  - Flush while the output is stalled: the flush waits. The requester holds flush high until flush_ack.
- blk_cnt wraps modulo 2^CW.
- Arithmetic: samples pass through bit-exact; there is no sign extension or scaling.

Test Plan:
- Reset, then stream 1, 2, 3, 4, 5, 6, 7, 8 with s_valid held high and blk_ready = 1 → blocks (1,2,3,4) and (5,6,7,8) on the cycles after samples 4 and 8; blk_fill = 4; blk_cnt = 2; s_ready stays 1.
- blk_ready = 0 after the first block, stream continues → s_ready drops when cnt = 3 with (5,6,7) held; output holds (1,2,3,4). Raise blk_ready → sample 8 is accepted and (5,6,7,8) appears next cycle with no lost or duplicated sample.
- Send -32768, 32767, then flush → block (-32768, 32767, 0, 0), blk_fill = 2, flush_ack pulses once.
- Flush with cnt = 0 → flush_ack pulses; blk_valid, blk_cnt and the output data are unchanged.
- Assert reset after 3 samples are accepted with a block pending → all outputs 0 immediately (asynchronous). Next samples 9, 10, 11, 12 → block (9,10,11,12).
- Accept 2^CW blocks with CW = 4 → blk_cnt wraps 15 → 0.

Source files
------------

// File: rtl/fir4_input_packer_if.sv
// ----------------------------------------------------------------------------
// fir4_input_packer_if
// Bundles the serial sample stream, the flush handshake and the 4-lane block
// output of the 4-parallel FIR input packer.
//   master : the packer side. It takes in samples, flush and blk_ready, and
//            drives s_ready, flush_ack and the block outputs.
//   slave  : the environment side. It drives samples and flush, and consumes
//            blocks.
// Signals:
//   s_data/s_valid/s_ready    serial signed sample stream (valid/ready)
//   flush/flush_ack           level request / one-cycle acknowledge
//   x4k..x4k_3                block lanes (x4k is the oldest sample)
//   blk_valid/blk_ready       block handshake
//   blk_fill                  number of real lanes in the block (1..4)
//   blk_cnt                   emitted-block counter (wraps)
// ----------------------------------------------------------------------------
interface fir4_input_packer_if #(
    parameter int DW = 16,
    parameter int CW = 16
);
    logic signed [DW-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 flush;
    logic                 flush_ack;
    logic signed [DW-1:0] x4k;
    logic signed [DW-1:0] x4k_1;
    logic signed [DW-1:0] x4k_2;
    logic signed [DW-1:0] x4k_3;
    logic                 blk_valid;
    logic                 blk_ready;
    logic [2:0]           blk_fill;
    logic [CW-1:0]        blk_cnt;

    modport master (
        input  s_data, s_valid, flush, blk_ready,
        output s_ready, flush_ack, x4k, x4k_1, x4k_2, x4k_3,
               blk_valid, blk_fill, blk_cnt
    );

    modport slave (
        output s_data, s_valid, flush, blk_ready,
        input  s_ready, flush_ack, x4k, x4k_1, x4k_2, x4k_3,
               blk_valid, blk_fill, blk_cnt
    );
endinterface

// File: rtl/fir4_input_packer.sv
// ----------------------------------------------------------------------------
// fir4_input_packer
// Packs a serial signed sample stream into blocks of four consecutive samples
// for a 4-parallel FIR. The block is double-buffered: a0..a2 hold the block
// being assembled while the output registers hold the previous block.
// A flush closes a partial block and zero-pads the lanes that were not filled.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, ACTIVE-HIGH despite its name (reset while 1)
//   bus    fir4_input_packer_if.master carrying the sample stream, the flush
//          handshake and the block outputs
// ----------------------------------------------------------------------------
module fir4_input_packer #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fir4_input_packer_if.master    bus
);
    // The state is the number of samples already held in a0..a2.
    typedef enum logic [1:0] {FILL0, FILL1, FILL2, FILL3} fill_state_e;

    fill_state_e          state, state_nxt;
    logic signed [DW-1:0] a      [3];
    logic signed [DW-1:0] a_nxt  [3];
    logic signed [DW-1:0] lane     [4];
    logic signed [DW-1:0] lane_nxt [4];
    logic signed [DW-1:0] merged   [4];
    logic                 valid_q, valid_nxt;
    logic [2:0]           fill_q, fill_nxt;
    logic [CW-1:0]        cnt_q, cnt_nxt;
    logic                 ack_q, ack_nxt;

    logic                 slot_free;
    logic                 accept;
    logic                 full_load;
    logic                 flush_load;
    logic [2:0]           cnt_post;

    // s_ready depends combinationally on blk_ready. It stalls only when the
    // fourth sample would need an output slot that is still occupied.
    assign slot_free   = !valid_q || bus.blk_ready;
    assign bus.s_ready = !(state == FILL3 && !slot_free);
    assign accept      = bus.s_valid && bus.s_ready;

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_nxt = state;
        a_nxt     = a;
        lane_nxt  = lane;
        valid_nxt = valid_q;
        fill_nxt  = fill_q;
        cnt_nxt   = cnt_q;
        ack_nxt   = 1'b0;

        // Number of samples held after this cycle's accept (4 = full block).
        cnt_post   = {1'b0, state} + {2'b0, accept};
        full_load  = accept && (state == FILL3);
        flush_load = bus.flush && !full_load && (cnt_post != 3'd0) && slot_free;

        // Post-accept view of the block: held samples, then the incoming
        // sample, then zero padding.
        merged[0] = (state != FILL0) ? a[0] : (accept ? bus.s_data : '0);
        merged[1] = (state == FILL2 || state == FILL3) ? a[1] :
                    ((state == FILL1 && accept) ? bus.s_data : '0);
        merged[2] = (state == FILL3) ? a[2] :
                    ((state == FILL2 && accept) ? bus.s_data : '0);
        merged[3] = (state == FILL3 && accept) ? bus.s_data : '0;

        if (accept && !full_load) begin
            case (state)
                FILL0:   a_nxt[0] = bus.s_data;
                FILL1:   a_nxt[1] = bus.s_data;
                default: a_nxt[2] = bus.s_data;
            endcase
            state_nxt = fill_state_e'(state + 2'd1);
        end

        if (full_load || flush_load) begin
            // A new load takes priority over a consume, so back-to-back
            // blocks leave blk_valid high with no bubble.
            lane_nxt  = merged;
            fill_nxt  = full_load ? 3'd4 : cnt_post;
            valid_nxt = 1'b1;
            cnt_nxt   = cnt_q + CW'(1);
            state_nxt = FILL0;
        end else if (valid_q && bus.blk_ready) begin
            valid_nxt = 1'b0;
        end

        // A flush with nothing to close is acknowledged at once. A flush
        // with data waits for a free output slot.
        ack_nxt = bus.flush && (full_load || flush_load || cnt_post == 3'd0);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= FILL0;
            // NOTE: the assembly registers are reset as well, so a partial
            // block is discarded and the zero-padded lanes never carry stale
            // data from before reset.
            for (int i = 0; i < 3; i++) a[i] <= '0;
            for (int i = 0; i < 4; i++) lane[i] <= '0;
            valid_q <= 1'b0;
            fill_q  <= 3'd0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only.
            // Every register then samples its pre-edge value.
            state   <= state_nxt;
            a       <= a_nxt;
            lane    <= lane_nxt;
            valid_q <= valid_nxt;
            fill_q  <= fill_nxt;
            cnt_q   <= cnt_nxt;
            ack_q   <= ack_nxt;
        end
    end

    assign bus.x4k       = lane[0];
    assign bus.x4k_1     = lane[1];
    assign bus.x4k_2     = lane[2];
    assign bus.x4k_3     = lane[3];
    assign bus.blk_valid = valid_q;
    assign bus.blk_fill  = fill_q;
    assign bus.blk_cnt   = cnt_q;
    assign bus.flush_ack = ack_q;
endmodule
